// File: rtl/store_merge_rmw_if.sv
// Memory-side bus of the store merge unit: word-aligned address, read/write
// strobes and data. The merge unit is the master, the data memory is the slave.
interface store_merge_rmw_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/store_merge_rmw.sv
// Sequenced read-modify-write for sub-word stores: reads the containing bus
// word, replaces the addressed byte lanes, writes it back; full-bus stores skip the read.
module store_merge_rmw #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           size,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    store_data,
    store_merge_rmw_if.master    mem,
    output logic                 busy,
    output logic                 done,
    output logic                 misalign_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               start_legal;
    logic               start_full;
    logic [NB-1:0]      lane_mask;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  merged;

    always_comb begin
        start_legal = 1'b0;
        case (size)
            2'b11:   start_legal = 1'b1;
            2'b10:   start_legal = ~addr[0];
            2'b01:   start_legal = (addr[1:0] == 2'b00);
            default: start_legal = (DATA_W == 64) && (addr[2:0] == 3'b000);
        endcase
        start_full = ((size == 2'b01) && (DATA_W == 32)) ||
                     ((size == 2'b00) && (DATA_W == 64));
    end

    // Store data is moved up to the target lane; the lane mask limits the
    // replacement to the store width so stale upper bits of store_data are ignored.
    always_comb begin
        lane_mask = '0;
        case (size_q)
            2'b11:   lane_mask = NB'(8'h01);
            2'b10:   lane_mask = NB'(8'h03);
            2'b01:   lane_mask = NB'(8'h0F);
            default: lane_mask = NB'(8'hFF);
        endcase
        lane_mask = lane_mask << off_q;
        shifted   = data_q << {off_q, 3'b000};
        merged    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            merged[8*i +: 8] = lane_mask[i] ? shifted[8*i +: 8] : mem.mem_rdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        size_d  = size_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    off_d  = addr[OFF_W-1:0];
                    size_d = size;
                    data_d = store_data;
                    err_d  = ~start_legal;
                    if (!start_legal) begin
                        state_d = S_DONE;
                    end else if (start_full) begin
                        wdata_d = store_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // The read word is merged as it is captured, so the write
                // register holds the final value by the time WRITE is entered.
                if (cnt_q == CNT_W'(1)) begin
                    wdata_d = merged;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_rd    = (state_q == S_READ);
    assign mem.mem_wr    = (state_q == S_WRITE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign misalign_err  = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_store_merge_rmw.sv
// Directed bench for store_merge_rmw: a 32-bit/MEM_LAT=1 and a 64-bit/MEM_LAT=3
// instance, each with a latency-accurate memory model driving mem_rdata.
module tb_store_merge_rmw;
    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start64;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] sdata;
    logic        busy32, done32, err32;
    logic        busy64, done64, err64;
    logic [31:0] mem32;
    logic [63:0] mem64;
    logic [7:0]  sr32, sr64;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    store_merge_rmw_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    store_merge_rmw_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .size(size), .addr(addr),
        .store_data(sdata[31:0]), .mem(bus32), .busy(busy32), .done(done32),
        .misalign_err(err32)
    );

    store_merge_rmw #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(3)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .size(size), .addr(addr),
        .store_data(sdata), .mem(bus64), .busy(busy64), .done(done64),
        .misalign_err(err64)
    );

    // Read data is valid only in the cycle MEM_LAT after the mem_rd cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr32 <= '0;
            sr64 <= '0;
        end else begin
            sr32 <= {sr32[6:0], bus32.mem_rd};
            sr64 <= {sr64[6:0], bus64.mem_rd};
        end
    end
    assign bus32.mem_rdata = sr32[0] ? mem32 : 32'h5A5A_5A5A;
    assign bus64.mem_rdata = sr64[2] ? mem64 : 64'hA5A5_A5A5_A5A5_A5A5;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run(input string tag, input bit w64, input logic [1:0] sz,
                       input logic [31:0] a, input logic [63:0] d, input logic [63:0] mv,
                       input logic [31:0] exp_ma, input logic [63:0] exp_wd, input bit exp_err,
                       input int exp_rd, input int exp_wr, input int exp_dn);
        int rd_c, wr_c, dn_c, n_rd, n_wr, both;
        logic [63:0] wd;
        logic [31:0] ma;
        logic err, busy1;
        logic o_rd, o_wr, o_dn, o_bz;
        @(negedge clk);
        size = sz; addr = a; sdata = d;
        if (w64) begin mem64 = mv; start64 = 1'b1; end
        else begin mem32 = mv[31:0]; start32 = 1'b1; end
        @(posedge clk);
        #1 start32 = 1'b0; start64 = 1'b0;
        rd_c = -1; wr_c = -1; dn_c = -1; n_rd = 0; n_wr = 0; both = 0;
        wd = '0; ma = '0; err = 1'b0; busy1 = 1'b0;
        for (int c = 1; c <= 20 && dn_c < 0; c++) begin
            @(negedge clk);
            o_rd = w64 ? bus64.mem_rd : bus32.mem_rd;
            o_wr = w64 ? bus64.mem_wr : bus32.mem_wr;
            o_dn = w64 ? done64 : done32;
            o_bz = w64 ? busy64 : busy32;
            if (c == 1) busy1 = o_bz;
            if (o_rd && o_wr) both++;
            if (o_rd) begin n_rd++; if (rd_c < 0) rd_c = c; end
            if (o_wr) begin
                n_wr++;
                if (wr_c < 0) wr_c = c;
                wd = w64 ? bus64.mem_wdata : {32'h0, bus32.mem_wdata};
            end
            if (o_dn) begin
                dn_c = c;
                err = w64 ? err64 : err32;
                ma = w64 ? bus64.mem_addr : bus32.mem_addr;
            end
        end
        check({tag, ".rd_cycle"}, rd_c, exp_rd);
        check({tag, ".rd_count"}, n_rd, (exp_rd < 0) ? 0 : 1);
        check({tag, ".wr_cycle"}, wr_c, exp_wr);
        check({tag, ".wr_count"}, n_wr, (exp_wr < 0) ? 0 : 1);
        check({tag, ".done_cycle"}, dn_c, exp_dn);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".mem_addr"}, ma, exp_ma);
        check({tag, ".busy"}, busy1, 1'b1);
        check({tag, ".rd_wr_overlap"}, both, 0);
        if (exp_wr > 0) check({tag, ".wdata"}, wd, exp_wd);
        @(negedge clk);
        check({tag, ".idle_after"}, w64 ? busy64 : busy32, 1'b0);
    endtask

    initial begin
        int n_dn, n_wr;
        logic bz5;
        logic [31:0] wd;
        reset = 1'b0; start32 = 1'b0; start64 = 1'b0;
        size = '0; addr = '0; sdata = '0; mem32 = '0; mem64 = '0;
        repeat (2) @(negedge clk);
        check("reset32.addr", bus32.mem_addr, 0);
        check("reset32.ctl", {bus32.mem_rd, bus32.mem_wr, busy32, done32, err32, bus32.mem_wdata}, 0);
        check("reset64.ctl", {bus64.mem_rd, bus64.mem_wr, busy64, done64, err64, bus64.mem_addr}, 0);
        reset = 1'b1;

        run("b_l3", 0, 2'b11, 32'h1003, 64'hAB, 64'h11223344, 32'h1000, 64'hAB223344, 0, 1, 3, 4);
        run("h_l2", 0, 2'b10, 32'h2002, 64'hFFFFBEEF, 64'hDEAD0000, 32'h2000, 64'hBEEF0000, 0, 1, 3, 4);
        run("h_l0", 0, 2'b10, 32'h2000, 64'hFFFFBEEF, 64'h12345678, 32'h2000, 64'h1234BEEF, 0, 1, 3, 4);
        run("b_l0", 0, 2'b11, 32'h3000, 64'hFFFFFF77, 64'hAABBCCDD, 32'h3000, 64'hAABBCC77, 0, 1, 3, 4);
        run("b_l1", 0, 2'b11, 32'h3001, 64'h5A, 64'h0, 32'h3000, 64'h00005A00, 0, 1, 3, 4);
        run("w_full", 0, 2'b01, 32'h40, 64'hCAFEF00D, 64'h0, 32'h40, 64'hCAFEF00D, 0, -1, 1, 2);
        run("h_mis", 0, 2'b10, 32'h41, 64'h1, 64'h0, 32'h40, 64'h0, 1, -1, -1, 1);
        run("w_mis", 0, 2'b01, 32'h42, 64'h1, 64'h0, 32'h40, 64'h0, 1, -1, -1, 1);
        run("d_on32", 0, 2'b00, 32'h50, 64'h1, 64'h0, 32'h50, 64'h0, 1, -1, -1, 1);

        run("w64_l4", 1, 2'b01, 32'h104, 64'h0000000099887766, 64'h0123456789ABCDEF,
            32'h100, 64'h9988776689ABCDEF, 0, 1, 5, 6);
        run("d64_full", 1, 2'b00, 32'h108, 64'h1122334455667788, 64'h0,
            32'h108, 64'h1122334455667788, 0, -1, 1, 2);
        run("b64_l7", 1, 2'b11, 32'h10F, 64'hEE, 64'h0123456789ABCDEF,
            32'h108, 64'hEE23456789ABCDEF, 0, 1, 5, 6);
        run("h64_l6", 1, 2'b10, 32'h106, 64'hBEEF, 64'h0,
            32'h100, 64'hBEEF000000000000, 0, 1, 5, 6);
        run("w64_mis", 1, 2'b01, 32'h102, 64'h1, 64'h0, 32'h100, 64'h0, 1, -1, -1, 1);
        run("d64_mis", 1, 2'b00, 32'h104, 64'h1, 64'h0, 32'h100, 64'h0, 1, -1, -1, 1);

        // Reset while waiting on the read.
        @(negedge clk);
        size = 2'b11; addr = 32'h1003; sdata = 64'hAB; mem32 = 32'h11223344; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid.addr", bus32.mem_addr, 0);
        check("rst_mid.ctl", {bus32.mem_rd, bus32.mem_wr, busy32, done32, err32, bus32.mem_wdata}, 0);
        n_wr = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus32.mem_wr) n_wr++;
        end
        check("rst_mid.no_write", n_wr, 0);
        reset = 1'b1;
        run("post_rst", 0, 2'b11, 32'h1003, 64'hAB, 64'h11223344, 32'h1000, 64'hAB223344, 0, 1, 3, 4);

        // Start pulses while busy and in the done cycle must be dropped.
        @(negedge clk);
        size = 2'b11; addr = 32'h1003; sdata = 64'hAB; mem32 = 32'h11223344; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        n_dn = 0; bz5 = 1'b1; wd = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done32) n_dn++;
            if (bus32.mem_wr) wd = bus32.mem_wdata;
            if (c == 5) bz5 = busy32;
            start32 = (c == 2) || (c == 4);
            if (c == 2) begin size = 2'b10; addr = 32'h41; end
        end
        start32 = 1'b0;
        check("busy_start.done_count", n_dn, 1);
        check("busy_start.wdata", wd, 32'hAB223344);
        check("done_start.busy", bz5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end
endmodule
